// File: rtl/jtkiwi_colmix.sv
// Colour mixer for the Kiwi/Seta X1 video path: layer priority, 512x15 palette lookup,
// blank-aligned RGB output, and a post-reset palette clear sequencer.
module jtkiwi_colmix #(
    parameter SIMFILE = "pal.bin"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [8:0] scr_pxl,
    input  logic [8:0] obj_pxl,
    input  logic [1:0] gfx_en,
    input  logic [9:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    input  logic       cpu_rnw,
    input  logic       pal_cs,
    output logic [7:0] cpu_din,
    output logic       busy,
    output logic [4:0] red,
    output logic [4:0] green,
    output logic [4:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);
    // A preloaded palette needs no clearing; an empty SIMFILE runs the clear.
    localparam bit SKIP_CLR = |SIMFILE;

    typedef enum logic { CLEAR, RUN } state_t;

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic [8:0]  idx_q, idx_d;
    logic [14:0] pal_q, pal_d;
    logic [14:0] rgb_q, rgb_d;
    // {LHBL, LVBL} through the three video stages
    logic [1:0]  blk1_q, blk1_d, blk2_q, blk2_d, blk3_q, blk3_d;

    logic [15:0] pal_mem [0:511];
    logic        we;
    logic [1:0]  wbe;
    logic [8:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] cpu_rd;

    // Port A: the clear sequencer owns the RAM until it finishes
    always_comb begin
        we    = 1'b0;
        wbe   = 2'b11;
        waddr = cnt_q;
        wdata = 16'h0000;
        if (state_q == CLEAR) begin
            we = 1'b1;
        end else if (pal_cs && !cpu_rnw) begin
            we    = 1'b1;
            waddr = cpu_addr[9:1];
            wdata = {cpu_dout, cpu_dout};
            wbe   = cpu_addr[0] ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            if (wbe[1]) pal_mem[waddr][15:8] <= wdata[15:8];
            if (wbe[0]) pal_mem[waddr][7:0]  <= wdata[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'h1ff) state_d = RUN;
        end
        busy_d = (state_d == CLEAR);

        cpu_rd    = pal_mem[cpu_addr[9:1]];
        cpu_din_d = 8'hff;
        if (state_q == RUN && pal_cs) cpu_din_d = cpu_addr[0] ? cpu_rd[7:0] : cpu_rd[15:8];
    end

    // Video path: stage 1 priority, stage 2 palette read, stage 3 blanked RGB
    always_comb begin
        idx_d  = idx_q;
        pal_d  = pal_q;
        rgb_d  = rgb_q;
        blk1_d = blk1_q;
        blk2_d = blk2_q;
        blk3_d = blk3_q;
        if (pxl_cen) begin
            if (obj_pxl[3:0] != 4'd0 && gfx_en[1]) idx_d = obj_pxl;
            else if (gfx_en[0])                      idx_d = scr_pxl;
            else                                     idx_d = 9'h000;
            blk1_d = {LHBL, LVBL};
            pal_d  = pal_mem[idx_q][14:0];
            blk2_d = blk1_q;
            blk3_d = blk2_q;
            rgb_d  = (&blk2_q) ? pal_q : 15'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SKIP_CLR ? RUN : CLEAR;
            cnt_q     <= 9'd0;
            busy_q    <= !SKIP_CLR;
            cpu_din_q <= 8'hff;
            idx_q     <= 9'd0;
            pal_q     <= 15'd0;
            rgb_q     <= 15'd0;
            blk1_q    <= 2'b00;
            blk2_q    <= 2'b00;
            blk3_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            cpu_din_q <= cpu_din_d;
            idx_q     <= idx_d;
            pal_q     <= pal_d;
            rgb_q     <= rgb_d;
            blk1_q    <= blk1_d;
            blk2_q    <= blk2_d;
            blk3_q    <= blk3_d;
        end
    end

    assign cpu_din  = cpu_din_q;
    assign busy     = busy_q;
    assign red      = rgb_q[14:10];
    assign green    = rgb_q[9:5];
    assign blue     = rgb_q[4:0];
    assign LHBL_dly = blk3_q[1];
    assign LVBL_dly = blk3_q[0];

endmodule

// File: tb/tb_jtkiwi_colmix.sv
// Bench for jtkiwi_colmix: directed and random CPU/pixel traffic against a palette array model.
module tb_jtkiwi_colmix;
    logic       clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, LHBL = 1'b1, LVBL = 1'b1;
    logic [8:0] scr_pxl = '0, obj_pxl = '0;
    logic [1:0] gfx_en = 2'b11;
    logic [9:0] cpu_addr = '0;
    logic [7:0] cpu_dout = '0;
    logic       cpu_rnw = 1'b1, pal_cs = 1'b0;
    logic [7:0] cpu_din;
    logic       busy, LHBL_dly, LVBL_dly;
    logic [4:0] red, green, blue;

    always #5 clk = ~clk;

    jtkiwi_colmix #(.SIMFILE("")) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .gfx_en(gfx_en),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw), .pal_cs(pal_cs),
        .cpu_din(cpu_din), .busy(busy), .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    int checks = 0, failures = 0;
    logic [15:0] pal_m [512];

    typedef struct { logic [14:0] rgb; logic hb; logic vb; } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [9:0] a, input logic [7:0] d);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
        tick();
        pal_cs = 1'b0; cpu_rnw = 1'b1;
        if (a[0]) pal_m[a[9:1]][7:0]  = d;
        else      pal_m[a[9:1]][15:8] = d;
    endtask

    task automatic cpu_rd_chk(input string tag, input logic [9:0] a);
        logic [15:0] w;
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
        tick();
        w = pal_m[a[9:1]];
        chk(tag, cpu_din, a[0] ? w[7:0] : w[15:8]);
        pal_cs = 1'b0;
    endtask

    // One pixel per two clocks; output compared once the pixel is three enables deep.
    task automatic pix(input string tag, input logic [8:0] s, input logic [8:0] o,
                       input logic [1:0] g, input logic hb, input logic vb);
        exp_t e;
        logic [8:0] idx;
        scr_pxl = s; obj_pxl = o; gfx_en = g; LHBL = hb; LVBL = vb;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        if (o[3:0] != 4'd0 && g[1]) idx = o;
        else if (g[0])              idx = s;
        else                        idx = 9'd0;
        e.rgb = (hb && vb) ? pal_m[idx][14:0] : 15'd0;
        e.hb = hb;
        e.vb = vb;
        q.push_back(e);
        if (q.size() == 3) begin
            e = q.pop_front();
            chk(tag, {red, green, blue}, e.rgb);
            chk({tag, "_blk"}, {LHBL_dly, LVBL_dly}, {e.hb, e.vb});
            tick();
            chk({tag, "_hold"}, {red, green, blue}, e.rgb);
        end else begin
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) pal_m[i] = 16'h0000;

        repeat (3) tick();
        chk("rst_rgb", {red, green, blue}, 15'd0);
        chk("rst_blk", {LHBL_dly, LVBL_dly}, 2'b00);
        chk("rst_busy", busy, 1'b1);
        chk("rst_din", cpu_din, 8'hff);

        // Clear sequence: 512 clocks busy, with a write and read attempted mid-way
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            pal_cs = (i == 100) || (i == 101);
            cpu_rnw = (i != 100);
            cpu_addr = 10'h00a;
            cpu_dout = 8'hab;
            tick();
            if (i == 101) chk("clr_rd_ff", cpu_din, 8'hff);
            if (i == 510) chk("busy_hi_511", busy, 1'b1);
        end
        pal_cs = 1'b0; cpu_rnw = 1'b1;
        chk("busy_lo_512", busy, 1'b0);
        cpu_rd_chk("clr_wr_ignored_hi", 10'h00a);
        cpu_rd_chk("clr_wr_ignored_lo", 10'h00b);
        cpu_rd_chk("clr_rd_last", 10'h3ff);

        // Directed palette contents
        cpu_wr(10'h002, 8'h7c);
        cpu_wr(10'h003, 8'h1f);
        cpu_rd_chk("e1_hi", 10'h002);
        cpu_rd_chk("e1_lo", 10'h003);
        tick();
        chk("din_idle_ff", cpu_din, 8'hff);
        cpu_wr(10'h224, 8'h03);
        cpu_wr(10'h225, 8'he0);
        cpu_wr(10'h000, 8'h2a);
        cpu_wr(10'h001, 8'h55);
        cpu_wr(10'h00a, 8'h12);
        cpu_wr(10'h00b, 8'h34);

        q.delete();
        repeat (3) pix("scr_e1", 9'h001, 9'h000, 2'b11, 1'b1, 1'b1);
        chk("e1_magenta", {red, green, blue}, {5'd31, 5'd0, 5'd31});
        repeat (3) pix("obj_pri", 9'h001, 9'h112, 2'b11, 1'b1, 1'b1);
        chk("obj_green", {red, green, blue}, {5'd0, 5'd31, 5'd0});
        repeat (3) pix("obj_transp", 9'h001, 9'h110, 2'b11, 1'b1, 1'b1);
        repeat (3) pix("gfx_off", 9'h005, 9'h112, 2'b00, 1'b1, 1'b1);
        repeat (3) pix("gfx_scr_only", 9'h001, 9'h112, 2'b01, 1'b1, 1'b1);
        repeat (3) pix("gfx_obj_only", 9'h005, 9'h003, 2'b10, 1'b1, 1'b1);
        pix("hbl_pre", 9'h001, 9'h000, 2'b11, 1'b1, 1'b1);
        pix("hbl_low", 9'h001, 9'h000, 2'b11, 1'b0, 1'b1);
        repeat (3) pix("hbl_post", 9'h001, 9'h000, 2'b11, 1'b1, 1'b1);
        pix("vbl_low", 9'h005, 9'h000, 2'b11, 1'b1, 1'b0);
        repeat (3) pix("vbl_post", 9'h005, 9'h000, 2'b11, 1'b1, 1'b1);

        // Random palette traffic, then random pixels over the resulting palette
        for (int i = 0; i < 80; i++) cpu_wr(10'($urandom), 8'($urandom));
        for (int i = 0; i < 20; i++) cpu_rd_chk("rnd_rd", 10'($urandom));
        q.delete();
        for (int i = 0; i < 80; i++) begin
            logic [8:0] o;
            o = 9'($urandom);
            if ($urandom_range(0, 3) == 0) o[3:0] = 4'd0;
            pix("rnd_pix", 9'($urandom), o, 2'($urandom),
                $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        end

        // Reset mid-frame
        pix("pre_rst", 9'h001, 9'h000, 2'b11, 1'b1, 1'b1);
        pxl_cen = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rgb", {red, green, blue}, 15'd0);
        chk("mid_rst_blk", {LHBL_dly, LVBL_dly}, 2'b00);
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_din", cpu_din, 8'hff);
        pxl_cen = 1'b0;
        tick();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 512; i++) pal_m[i] = 16'h0000;
        repeat (511) tick();
        chk("re_busy_hi_511", busy, 1'b1);
        tick();
        chk("re_busy_lo_512", busy, 1'b0);
        for (int a = 0; a < 1024; a++) cpu_rd_chk("post_rst_rd", 10'(a));
        q.delete();
        repeat (3) pix("post_rst_pix", 9'($urandom), 9'($urandom), 2'b11, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtkiwi_colmix.md
# jtkiwi_colmix

Colour mixer and palette stage directly downstream of the Kiwi/Seta X1 graphics block. Each pixel it takes the 9-bit tilemap and object pixels, resolves priority, and looks the result up in a 512-entry, 15-bit palette RAM written by the main CPU. It delays the blanking signals to match the lookup and drives blanked 5-bit RGB to the video output. After reset it clears the palette RAM with an internal state machine.

## Interface
Parameters:
- SIMFILE, "pal.bin": palette RAM preload, simulation only. When set, the clear FSM is skipped in simulation.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pxl_cen  in  1  pixel clock enable
- LHBL  in  1  horizontal blank, active low, aligned with the incoming pixels
- LVBL  in  1  vertical blank, active low, aligned with the incoming pixels
- scr_pxl  in  9  tilemap pixel: [8:4] palette bank, [3:0] colour
- obj_pxl  in  9  object pixel, same format
- gfx_en  in  2  debug layer enables: [0] tilemap, [1] objects
- cpu_addr  in  10  byte address into palette RAM
- cpu_dout  in  8  CPU write data
- cpu_rnw  in  1  1 = read, 0 = write
- pal_cs  in  1  palette select, synchronous to clk
- cpu_din  out  8  CPU read data
- busy  out  1  high while the clear FSM runs
- red, green, blue  out  5 each  pixel colour
- LHBL_dly, LVBL_dly  out  1 each  blanking aligned with the RGB outputs

## Operation
- Palette word format: [14:10] R, [9:5] G, [4:0] B; bit 15 is stored and read back but unused.
- Entry n is addressed by cpu_addr[9:1]=n.
  - cpu_addr[0]=0 selects the high byte (15:8).
  - cpu_addr[0]=1 selects the low byte (7:0).
- RAM is dual-port: port A for the CPU/clear FSM, port B for the video read. There is no contention.
- Priority:
  - If obj_pxl[3:0]!=0 and gfx_en[1], the index is obj_pxl.
  - Else, if gfx_en[0], the index is scr_pxl (colour 0 included).
  - Else the index is 9'h000.
- Clear FSM states:
  - CLEAR: entered on reset. busy=1. Writes 16'h0000 to address cnt, with cnt incrementing every clk from 0 to 511.
  - RUN: entered after cnt=511 is written. busy=0.
- During CLEAR:
  - CPU writes are ignored.
  - CPU reads return 8'hFF.
  - The video path still runs; RGB reads whatever is in RAM.
- In RUN:
  - A CPU write with pal_cs & ~cpu_rnw writes the selected byte on that clk edge.
  - CPU reads return the byte one clk later. cpu_din is registered and reads 8'hFF when pal_cs=0.
- Reset mid-operation: all registers return to their reset values and the FSM restarts CLEAR at cnt=0. RAM contents already written are not guaranteed.

## Timing
- Reset values: red=green=blue=0, LHBL_dly=LVBL_dly=0, busy=1, cpu_din=8'hFF.
- Video pipeline advances only on pxl_cen, in three stages:
  - Stage 1: the priority mux registers the index; LHBL/LVBL are registered.
  - Stage 2: RAM port B read.
  - Stage 3: RGB output register.
- Latency from the input pixel to RGB is 3 pxl_cen.
- LHBL_dly/LVBL_dly use the same 3-pxl_cen delay.
- RGB is forced to 0 when LHBL_dly=0 or LVBL_dly=0 at stage 3.
- A CPU write to an entry currently being read by the video path is visible on the next pxl_cen read.
- Clear duration is exactly 512 clk cycles; busy falls on the clk after the last write.
- pxl_cen held low: outputs and pipeline hold; the clear FSM and CPU port still operate.

## Test plan
- Reset release -> busy high for 512 clk, then low. Reads of any address return 8'h00. A write issued during clear has no effect.
- CPU writes 8'h7C to addr 0x002 and 8'h1F to 0x003 (entry 1 = 0x7C1F) -> readback 0x7C / 0x1F. scr_pxl=9'h001, obj_pxl=0 -> after 3 pxl_cen: red=31, green=0, blue=31.
- Priority: obj_pxl=9'h112 (entry 0x112 = 0x03E0) with scr_pxl=9'h001 -> green=31, red=blue=0. Then obj_pxl=9'h110 (colour 0) -> falls back to entry 1.
- gfx_en=2'b00 -> index 0 is used regardless of inputs. gfx_en=2'b01 with a non-transparent object -> tilemap colour is shown.
- Blanking: LHBL low for 1 pxl_cen while the inputs point to a non-zero entry -> LHBL_dly low exactly 3 pxl_cen later, with RGB=0 on that pixel only.
- Assert rst mid-frame after palette writes -> outputs return to 0, busy=1, clear restarts from cnt=0, and after 512 clk all entries read back 0.
